// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// Samples a synchronised RX line at bit centres and reports each byte.
module uart_rx #(
  parameter int DIV_RATE = 260,
  parameter int DIV_W    = 9
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       rx,
  output logic       rx_busy,
  output logic       rx_end,
  output logic [7:0] rx_data,
  output logic       rx_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] HALF = DIV_W'(DIV_RATE / 2 - 1);
  localparam logic [DIV_W-1:0] FULL = DIV_W'(DIV_RATE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_nxt;
  logic [7:0]       data_nxt;
  logic             busy_nxt;
  logic             end_nxt;
  logic             err_nxt;
  logic             rx_m;
  logic             rx_s;
  logic             div_zero;

  assign div_zero = (div_cnt == '0);

  // Two-flop synchroniser for the asynchronous pad input
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      rx_data <= 8'h00;
      rx_busy <= 1'b0;
      rx_end  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      rx_data <= data_nxt;
      rx_busy <= busy_nxt;
      rx_end  <= end_nxt;
      rx_err  <= err_nxt;
    end
  end

  // Next state: counters are reloaded on every transition, never wrap
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    data_nxt  = rx_data;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          div_nxt   = HALF;
        end
      end
      START: begin
        if (!div_zero) begin
          div_nxt = div_cnt - 1'b1;
        end else if (!rx_s) begin
          state_nxt = DATA;
          div_nxt   = FULL;
          bit_nxt   = 3'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!div_zero) begin
          div_nxt = div_cnt - 1'b1;
        end else begin
          data_nxt[bit_cnt] = rx_s;
          div_nxt           = FULL;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (!div_zero) begin
          div_nxt = div_cnt - 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, registered alongside the state
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    end_nxt  = (state == STOP) && div_zero && rx_s;
    err_nxt  = (state == STOP) && div_zero && !rx_s;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx.
// A frame-level model predicts byte, error flag and latency per frame.
module tb_uart_rx;

  logic       clk;
  logic       reset_;
  logic       rx;
  logic       rx_busy;
  logic       rx_end;
  logic [7:0] rx_data;
  logic       rx_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         start;
    logic       lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic prev_pulse = 1'b0;

  uart_rx #(
    .DIV_RATE(16),
    .DIV_W   (5)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .rx     (rx),
    .rx_busy(rx_busy),
    .rx_end (rx_end),
    .rx_data(rx_data),
    .rx_err (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Every pulse must match the oldest predicted frame
  always @(negedge clk) begin
    if (rx_end || rx_err) begin
      check("excl", 32'(rx_end & rx_err), 0);
      check("twice", 32'(prev_pulse), 0);
      check("pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("kind_err", 32'(rx_err), 32'(e.err));
        check("data", 32'(rx_data), 32'(e.data));
        if (e.lat) begin
          check("lat", 32'((cyc - e.start >= 154) && (cyc - e.start <= 156)), 1);
        end
      end
    end
    prev_pulse = rx_end | rx_err;
  end

  // Drive one 8N1 frame; caller is just after a posedge
  task automatic send(input logic [7:0] b, input int per,
                      input logic stp, input logic lat, input logic bsy);
    logic [9:0] fr;
    int         s;
    exp_t       x;
    fr = {stp, b, 1'b0};
    #1;
    rx = 1'b0;
    s = cyc;
    x.data  = b;
    x.err   = ~stp;
    x.start = s;
    x.lat   = lat;
    exp_q.push_back(x);
    for (int k = 1; k <= per * 10; k++) begin
      @(posedge clk);
      #1;
      if (bsy && k == 2) check("busy_pre", 32'(rx_busy), 0);
      if (bsy && k == 3) check("busy_on", 32'(rx_busy), 1);
      if (bsy && k == 100) check("busy_mid", 32'(rx_busy), 1);
      if (k % per == 0 && k < per * 10) rx = fr[k/per];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [9:0] fr;
    logic       stp;
    rx     = 1'b1;
    reset_ = 1'b0;
    idle(3);
    #1;
    check("rst_busy", 32'(rx_busy), 0);
    check("rst_end", 32'(rx_end), 0);
    check("rst_err", 32'(rx_err), 0);
    check("rst_data", 32'(rx_data), 0);
    reset_ = 1'b1;
    idle(5);

    send(8'hA5, 16, 1'b1, 1'b1, 1'b1);
    drain();
    idle(10);

    #1;
    rx = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) rx = 1'b1;
      if (k == 2) check("gl_pre", 32'(rx_busy), 0);
      if (k == 6) check("gl_busy", 32'(rx_busy), 1);
      if (k == 13) check("gl_idle", 32'(rx_busy), 0);
    end
    send(8'h3C, 16, 1'b1, 1'b1, 1'b0);
    drain();
    idle(10);

    send(8'h81, 16, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    drain();
    idle(20);
    #1;
    check("err_idle", 32'(rx_busy), 0);
    send(8'h55, 16, 1'b1, 1'b1, 1'b0);
    drain();
    idle(10);

    send(8'h00, 16, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 16, 1'b1, 1'b1, 1'b0);
    send(8'h5A, 16, 1'b1, 1'b1, 1'b0);
    drain();
    idle(10);

    send(8'hC3, 15, 1'b1, 1'b0, 1'b0);
    idle(20);
    send(8'hC3, 17, 1'b1, 1'b0, 1'b0);
    drain();
    idle(20);

    fr = {1'b1, 8'h6B, 1'b0};
    #1;
    rx = 1'b0;
    for (int k = 1; k <= 88; k++) begin
      @(posedge clk);
      #1;
      if (k % 16 == 0) rx = fr[k/16];
    end
    reset_ = 1'b0;
    #1;
    check("ar_busy", 32'(rx_busy), 0);
    check("ar_end", 32'(rx_end), 0);
    check("ar_err", 32'(rx_err), 0);
    check("ar_data", 32'(rx_data), 0);
    rx = 1'b1;
    idle(5);
    #1;
    reset_ = 1'b1;
    idle(5);
    send(8'h96, 16, 1'b1, 1'b1, 1'b0);
    drain();
    idle(10);

    for (int n = 0; n < 30; n++) begin
      stp = ($urandom_range(0, 7) != 0);
      send(8'($urandom), 16, stp, 1'b1, 1'b0);
      rx = 1'b1;
      if (!stp) idle(12 + $urandom_range(0, 8));
      else idle($urandom_range(0, 6));
    end
    drain();
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
